// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Owns HI/LO and stalls
// the front of the pipeline while an operation is in flight.
module ex_muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [1:0]   op_in,
  input  logic [W-1:0] src_a_in,
  input  logic [W-1:0] src_b_in,
  input  logic         flush_in,
  input  logic         hi_we_in,
  input  logic         lo_we_in,
  input  logic [W-1:0] wdata_in,
  output logic         stall_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         div0_out,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;
  logic           done_q, done_d;

  logic           accept_s;
  logic           sgn_op_s;
  logic [W-1:0]   abs_a_s, abs_b_s, quot_s, rem_s;
  logic [W:0]     mul_sum_s, div_tmp_s, div_diff_s;
  logic [2*W-1:0] prod_s;

  assign sgn_op_s   = ~op_in[0];
  assign abs_a_s    = (sgn_op_s && src_a_in[W-1]) ? -src_a_in : src_a_in;
  assign abs_b_s    = (sgn_op_s && src_b_in[W-1]) ? -src_b_in : src_b_in;
  assign accept_s   = (state_q == S_IDLE) && start_in && !done_q && !flush_in;

  // opnd_q holds the multiplicand (mult) or divisor (div); acc_q is {hi, lo} working pair
  assign mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign div_tmp_s  = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff_s = div_tmp_s - {1'b0, opnd_q};
  assign prod_s     = neg_res_q ? -acc_q : acc_q;
  assign quot_s     = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_s      = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  // Next-state, datapath iteration and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d   = S_CALC;
          cnt_d     = {CW{1'b0}};
          is_div_d  = op_in[1];
          opnd_d    = op_in[1] ? abs_b_s : abs_a_s;
          acc_d     = {{W{1'b0}}, (op_in[1] ? abs_a_s : abs_b_s)};
          neg_res_d = sgn_op_s & (src_a_in[W-1] ^ src_b_in[W-1]);
          neg_rem_d = sgn_op_s & src_a_in[W-1];
          a_raw_d   = src_a_in;
          div0_d    = 1'b0;
        end else begin
          hi_d = hi_we_in ? wdata_in : hi_q;
          lo_d = lo_we_in ? wdata_in : lo_q;
        end
      end
      S_CALC: begin
        if (flush_in) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_diff_s[W] ? {div_tmp_s[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
          end else begin
            acc_d = acc_q[0] ? {mul_sum_s, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
          end
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = (cnt_q == CW'(W-1)) ? S_FIX : S_CALC;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (flush_in) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_s[2*W-1:W];
            lo_d = prod_s[W-1:0];
          end else if (opnd_q == {W{1'b0}}) begin
            hi_d   = a_raw_q;
            lo_d   = {W{1'b1}};
            div0_d = 1'b1;
          end else begin
            hi_d = rem_s;
            lo_d = quot_s;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      opnd_q    <= {W{1'b0}};
      a_raw_q   <= {W{1'b0}};
      acc_q     <= {(2*W){1'b0}};
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_out  = (state_q != S_IDLE);
  assign stall_out = busy_out | (start_in & ~done_q);
  assign done_out  = done_q;
  assign div0_out  = div0_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the operands and operation decoded out of the ID/EX stage register and owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU over W+2 cycles. While it is busy it asserts a stall that freezes the ID/EX register and the upstream stages.

Parameters:
W, 32, operand width; iteration count equals W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start_in  in  1  decoded mul/div instruction present in EX
op_in  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
src_a_in  in  W  rs operand (Reg1 after forwarding)
src_b_in  in  W  rt operand (Reg2 after forwarding)
flush_in  in  1  kill the in-flight operation (branch/exception flush)
hi_we_in  in  1  MTHI write enable
lo_we_in  in  1  MTLO write enable
wdata_in  in  W  MTHI/MTLO data
stall_out  out  1  freeze ID/EX and earlier stages (combinational)
busy_out  out  1  state != IDLE
done_out  out  1  one-cycle pulse when HI/LO are updated
div0_out  out  1  last division had a zero divisor
hi_out  out  W  HI register
lo_out  out  W  LO register

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - hi_out, lo_out, done_out, div0_out, busy_out = 0.
  - Internal accumulators cleared.
  - Reset mid-operation abandons the operation without updating HI/LO.
- FSM: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: start is accepted when start_in=1, done_out=0 and flush_in=0.
    - Latch |a| and |b| (signed ops only; unsigned ops pass through), the result-sign bits, and op.
    - Clear counter and accumulators; go to CALC.
  - CALC: exactly W cycles, one bit per cycle.
    - Multiply: radix-2 shift-add into a 2W-bit product.
    - Divide: restoring shift-subtract, producing quotient and remainder.
    - Counter reaches W-1 -> FIX.
  - FIX: one cycle.
    - Apply sign correction and write HI/LO.
    - Pulse done_out for one cycle, registered with the HI/LO update.
    - Return to IDLE.
- Latency: start sampled at edge T; busy_out=1 for edges T+1..T+W+1; HI/LO and done_out valid after edge T+W+2 (34 cycles for W=32).
- stall_out = (state != IDLE) | (start_in & ~done_out).
  - The pipeline stays frozen while the instruction is held.
  - In the done_out cycle stall drops, so the held instruction advances without re-triggering.
- Arithmetic:
  - MULT(U): {HI,LO} = 2W-bit product. For MULT, negate the product when sign(a) xor sign(b).
  - DIV(U): LO = quotient, HI = remainder.
    - Signed: quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
    - -2^(W-1) / -1 gives LO = 0x80000000 and HI = 0 (natural wrap, no trap).
  - Divisor 0 (DIV or DIVU): LO = all ones, HI = src_a_in unmodified, no sign fix, div0_out=1.
    - Still takes the full W+2 cycles.
    - div0_out holds until the next accepted start, which clears it.
- flush_in:
  - In CALC/FIX: return to IDLE next edge; HI/LO unchanged; no done_out.
  - In IDLE: blocks acceptance of a start.
  - Flush has priority over the FIX-cycle write.
- MTHI/MTLO:
  - hi_we_in / lo_we_in update HI / LO only in IDLE with no start accepted that cycle.
  - While busy they are ignored; stall holds the instruction until IDLE.
  - An accepted start beats a simultaneous write.
- Operands are sampled only at acceptance; later changes on src_a_in/src_b_in/op_in are ignored.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, done_out pulses once, stall_out low that cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100 b=0 -> LO=0xFFFFFFFF, HI=0x00000064, div0_out=1; next DIVU 100/7 -> LO=14, HI=2, div0_out=0.
- DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI/LO preloaded via MTHI=0x11, MTLO=0x22; start MULTU 5*6, assert flush_in at CALC cycle 10 -> IDLE next edge, HI=0x11, LO=0x22, no done_out.
- start held high through busy with MTLO asserted -> exactly one operation and one done_out; MTLO ignored while busy. Separately, rst=0 mid-CALC -> all outputs 0 immediately.
